// File: rtl/uart_tx_hold.sv
// uart_tx_hold: one-word transmit holding register feeding a UART serializer.
// The host can queue the next byte while the current frame is shifting out.
module uart_tx_hold #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            wr_uart,
    input  logic [DBIT-1:0] w_data,
    output logic            tx_full,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_BIT  = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] buf_q, buf_d;
    logic            full_q, full_d;
    logic            tx_q, tx_d;
    logic            take;
    logic            done;

    // Register all state; the line idles high and snaps back on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            tx_q    <= tx_d;
        end
    end

    // Holding register: a take and a write in one cycle keeps it full.
    always_comb begin
        take   = (state_q == IDLE) && full_q;
        buf_d  = buf_q;
        full_d = full_q;
        if (take) begin
            full_d = 1'b0;
        end
        if (wr_uart && (!full_q || take)) begin
            buf_d  = w_data;
            full_d = 1'b1;
        end
    end

    // Serializer next state; IDLE leaves on a take without waiting for a tick.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = START;
                    s_d     = '0;
                    b_d     = buf_q;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        s_d     = '0;
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level follows the next state so tx comes straight from a flop.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx           = tx_q;
    assign tx_full      = full_q;
    assign tx_busy      = (state_q != IDLE);
    assign tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx_hold.sv
// tb_uart_tx_hold: directed vectors and hand-built multi-cycle sequences
// for the holding register and serializer, with SB_TICK of 16 and 32.
module tb_uart_tx_hold;

    typedef struct {
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       full16, busy16, done16, tx16;
    logic       full32, busy32, done32, tx32;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dcnt16 = 0;
    int dcnt32 = 0;
    int dcyc16 = 0;
    int dcyc32 = 0;

    uart_tx_hold #(.DBIT(8), .SB_TICK(16)) u16 (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .wr_uart(wr_uart), .w_data(w_data),
        .tx_full(full16), .tx_busy(busy16),
        .tx_done_tick(done16), .tx(tx16)
    );

    uart_tx_hold #(.DBIT(8), .SB_TICK(32)) u32 (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .wr_uart(wr_uart), .w_data(w_data),
        .tx_full(full32), .tx_busy(busy32),
        .tx_done_tick(done32), .tx(tx32)
    );

    always #5 clk = ~clk;

    // s_tick every 4 clk, cycle counter, and done-tick monitor
    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            s_tick = (cyc % 4 == 0);
            #1;
            if (done16 === 1'b1) begin
                dcnt16++;
                dcyc16 = cyc;
            end
            if (done32 === 1'b1) begin
                dcnt32++;
                dcyc32 = cyc;
            end
        end
    end

    function automatic logic txs(input bit sel);
        return sel ? tx32 : tx16;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act,
                           input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        wr_uart = 1'b1;
        w_data  = d;
        step();
        wr_uart = 1'b0;
    endtask

    task automatic run_len(input bit sel, output int len);
        logic v;
        v   = txs(sel);
        len = 0;
        while (txs(sel) === v && len < 400) begin
            step();
            len++;
        end
    endtask

    // off: samples already spent inside the start bit when called
    task automatic rx_byte(input bit sel, input int off,
                           output logic [7:0] d, output int sc);
        int k;
        d = '0;
        k = 0;
        while (txs(sel) !== 1'b0 && k < 4000) begin
            step();
            k++;
        end
        sc = cyc;
        chk("rx_start_seen", txs(sel), 0);
        step(32 - off);
        chk("rx_start_mid", txs(sel), 0);
        for (int i = 0; i < 8; i++) begin
            step(64);
            d[i] = txs(sel);
        end
        step(64);
        chk("rx_stop_mid", txs(sel), 1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy16 | busy32 | full16 | full32) !== 1'b0 && k < 5000) begin
            step();
            k++;
        end
        chk("idle_reached", busy16 | busy32 | full16 | full32, 0);
        step(8);
    endtask

    initial begin
        vec_t       tbl[5];
        logic [7:0] d;
        logic [7:0] pat;
        int         sc, len, base, base32, stop_start, k, lows;

        reset   = 1'b1;
        wr_uart = 1'b0;
        w_data  = '0;
        tbl[0] = '{8'h00, 8'h00};
        tbl[1] = '{8'hFF, 8'hFF};
        tbl[2] = '{8'h80, 8'h80};
        tbl[3] = '{8'h01, 8'h01};
        tbl[4] = '{8'hA5, 8'hA5};

        step(3);
        chk("rst_tx", tx16, 1);
        chk("rst_full", full16, 0);
        chk("rst_busy", busy16, 0);
        chk("rst_done", done16, 0);
        chk("rst_tx32", tx32, 1);
        reset = 1'b0;
        step(2);

        // 0x55: full timing, per-bit run lengths, stop length, one done
        base = dcnt16;
        pat  = 8'h55;
        wr(8'h55);
        chk("t1_full_rise", full16, 1);
        chk("t1_tx_still_idle", tx16, 1);
        step();
        chk("t1_full_fall", full16, 0);
        chk("t1_busy", busy16, 1);
        chk("t1_start_bit", tx16, 0);
        run_len(0, len);
        chk_rng("t1_start_len", len, 61, 64);
        for (int i = 0; i < 8; i++) begin
            chk("t1_data_bit", tx16, pat[i]);
            run_len(0, len);
            chk("t1_bit_len", len, 64);
        end
        stop_start = cyc;
        chk("t1_stop_bit", tx16, 1);
        k = 0;
        while (dcnt16 == base && k < 200) begin
            step();
            k++;
        end
        chk("t1_done_seen", dcnt16 - base, 1);
        chk("t1_stop_len", dcyc16 - stop_start, 63);
        wait_idle();
        chk("t1_one_done", dcnt16 - base, 1);

        // 0xA3 then 0x0F queued during the start bit
        wr(8'hA3);
        step();
        chk("t2_start", tx16, 0);
        wr(8'h0F);
        chk("t2_full", full16, 1);
        rx_byte(0, 1, d, sc);
        chk("t2_byte_a3", d, 8'hA3);
        chk("t2_full_held", full16, 1);
        rx_byte(0, 0, d, sc);
        chk("t2_byte_0f", d, 8'h0F);
        chk("t2_gap", sc - dcyc16, 2);
        wait_idle();

        // write while full is dropped
        base = dcnt16;
        wr(8'h3C);
        step();
        wr(8'hC5);
        wr(8'h77);
        chk("t3_full", full16, 1);
        rx_byte(0, 2, d, sc);
        chk("t3_byte_3c", d, 8'h3C);
        rx_byte(0, 0, d, sc);
        chk("t3_byte_c5", d, 8'hC5);
        wait_idle();
        chk("t3_two_frames", dcnt16 - base, 2);

        // write in the same cycle as a take
        wr(8'h12);
        chk("t4_full", full16, 1);
        wr(8'h34);
        chk("t4_full_kept", full16, 1);
        chk("t4_start", tx16, 0);
        rx_byte(0, 0, d, sc);
        chk("t4_byte_12", d, 8'h12);
        rx_byte(0, 0, d, sc);
        chk("t4_byte_34", d, 8'h34);
        chk("t4_gap", sc - dcyc16, 2);
        wait_idle();

        // single-frame vector table
        for (int v = 0; v < 5; v++) begin
            base = dcnt16;
            wr(tbl[v].d);
            chk("tbl_full", full16, 1);
            rx_byte(0, 0, d, sc);
            chk("tbl_byte", d, tbl[v].exp);
            wait_idle();
            chk("tbl_one_done", dcnt16 - base, 1);
        end

        // SB_TICK=32 versus 16 on the same 0xFF frame
        base   = dcnt16;
        base32 = dcnt32;
        wr(8'hFF);
        step();
        chk("t5_start32", tx32, 0);
        sc = cyc;
        k  = 0;
        while (dcnt32 == base32 && k < 1000) begin
            step();
            k++;
        end
        chk("t5_done32_seen", dcnt32 - base32, 1);
        chk_rng("t5_sb16_frame", dcyc16 - sc, 636, 639);
        chk_rng("t5_sb32_frame", dcyc32 - sc, 700, 703);
        wait_idle();
        chk("t5_one_done16", dcnt16 - base, 1);
        chk("t5_one_done32", dcnt32 - base32, 1);

        // reset during data bit 3 with a byte pending
        wr(8'h00);
        step();
        wr(8'h5A);
        chk("t6_full", full16, 1);
        step(289);
        chk("t6_tx_data", tx16, 0);
        chk("t6_busy", busy16, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_tx", tx16, 1);
        chk("t6_rst_full", full16, 0);
        chk("t6_rst_busy", busy16, 0);
        chk("t6_rst_tx32", tx32, 1);
        step(2);
        reset  = 1'b0;
        base   = dcnt16;
        base32 = dcnt32;
        lows   = 0;
        repeat (1000) begin
            step();
            if (tx16 !== 1'b1 || tx32 !== 1'b1) lows++;
        end
        chk("t6_line_high", lows, 0);
        chk("t6_no_done", (dcnt16 - base) + (dcnt32 - base32), 0);
        chk("t6_idle_full", full16, 0);
        chk("t6_idle_busy", busy16, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
